// File: rtl/csma_backoff_if.sv
// Channel-access interface between the tx scheduler and the CSMA/CA backoff block.
interface csma_backoff_if;
  logic       ch_idle;
  logic       tx_req;
  logic       tx_done;
  logic [7:0] difs_us;
  logic [4:0] slot_us;
  logic [3:0] cw_exp;
  logic       tx_grant;
  logic       backoff_busy;
  logic [9:0] backoff_left;

  modport master (
    output ch_idle, tx_req, tx_done, difs_us, slot_us, cw_exp,
    input  tx_grant, backoff_busy, backoff_left
  );

  modport slave (
    input  ch_idle, tx_req, tx_done, difs_us, slot_us, cw_exp,
    output tx_grant, backoff_busy, backoff_left
  );
endinterface

// File: rtl/csma_backoff.sv
// CSMA/CA defer + random slot backoff ahead of a pending transmission.
// Defers DIFS of continuous idle, counts down idle slots (frozen on busy,
// which forces a fresh DIFS), then grants the medium until tx_done.
module csma_backoff #(
  parameter int unsigned CLK_PER_US = 100,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic          clk,
  input logic          rstn,
  csma_backoff_if.slave bus
);

  localparam int unsigned TICK_W = 16;
  localparam int unsigned LEFT_W = 10;
  localparam int unsigned CW_MAX = 10;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [TICK_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DIFS = 2'd1,
    BACKOFF   = 2'd2,
    GRANT     = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [TICK_W-1:0]   difs_ticks, slot_ticks, slot_len;
  logic [TICK_W-1:0]   idle_cnt, idle_cnt_d;
  logic [TICK_W-1:0]   slot_cnt, slot_cnt_d;
  logic [TICK_W:0]     idle_next, slot_next;
  logic [TICK_W-1:0]   lfsr, lfsr_d;
  logic [LEFT_W-1:0]   left, left_d, cw_mask;
  logic                grant, grant_d;

  // Tick targets re-registered every cycle so config changes land one cycle later
  always_ff @(posedge clk) begin
    if (!rstn) begin
      difs_ticks <= '0;
      slot_ticks <= '0;
    end else begin
      difs_ticks <= TICK_W'(32'(bus.difs_us) * CLK_PER_US);
      slot_ticks <= TICK_W'(32'(bus.slot_us) * CLK_PER_US);
    end
  end

  // Contention-window mask and counter look-ahead values
  always_comb begin
    if (bus.cw_exp >= 4'(CW_MAX)) begin
      cw_mask = '1;
    end else begin
      cw_mask = LEFT_W'((11'd1 << bus.cw_exp) - 11'd1);
    end
    slot_len  = (slot_ticks == '0) ? TICK_W'(1) : slot_ticks;
    idle_next = {1'b0, idle_cnt} + 17'd1;
    slot_next = {1'b0, slot_cnt} + 17'd1;
    lfsr_d    = {1'b0, lfsr[TICK_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state;
    idle_cnt_d = idle_cnt;
    slot_cnt_d = slot_cnt;
    left_d     = left;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tx_req) begin
          left_d     = lfsr[LEFT_W-1:0] & cw_mask;
          idle_cnt_d = '0;
          state_d    = WAIT_DIFS;
        end
      end
      WAIT_DIFS: begin
        if (!bus.tx_req) begin
          left_d     = '0;
          idle_cnt_d = '0;
          state_d    = IDLE;
        end else if (!bus.ch_idle) begin
          idle_cnt_d = '0;
        end else if (idle_next >= {1'b0, difs_ticks}) begin
          idle_cnt_d = '0;
          slot_cnt_d = '0;
          state_d    = (left == '0) ? GRANT : BACKOFF;
        end else begin
          idle_cnt_d = idle_next[TICK_W-1:0];
        end
      end
      BACKOFF: begin
        if (!bus.tx_req) begin
          left_d     = '0;
          slot_cnt_d = '0;
          state_d    = IDLE;
        end else if (!bus.ch_idle) begin
          // busy wins over a coinciding slot completion
          slot_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = WAIT_DIFS;
        end else if (slot_next >= {1'b0, slot_len}) begin
          slot_cnt_d = '0;
          left_d     = left - LEFT_W'(1);
          if (left == LEFT_W'(1)) begin
            state_d = GRANT;
          end
        end else begin
          slot_cnt_d = slot_next[TICK_W-1:0];
        end
      end
      GRANT: begin
        if (bus.tx_done) begin
          state_d = IDLE;
        end else begin
          grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, LFSR and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      idle_cnt <= '0;
      slot_cnt <= '0;
      left     <= '0;
      grant    <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      state    <= state_d;
      idle_cnt <= idle_cnt_d;
      slot_cnt <= slot_cnt_d;
      left     <= left_d;
      grant    <= grant_d;
      lfsr     <= lfsr_d;
    end
  end

  assign bus.tx_grant     = grant;
  assign bus.backoff_left = left;
  assign bus.backoff_busy = (state == WAIT_DIFS) || (state == BACKOFF);

endmodule

// File: doc/csma_backoff.md
Name: csma_backoff

Overview:
- Transmit-side consumer of the channel-idle indication: runs the CSMA/CA defer/backoff procedure before a pending transmission.
- Waits DIFS/AIFS of continuous channel idle, then counts down a random number of idle slots; frozen whenever the channel goes busy.
- Raises tx_grant to the tx control logic when the countdown completes.
- Sits in xpu between the channel-idle generator and the tx scheduler.

Parameters:
- CLK_PER_US, 100: clk cycles per microsecond; 16-bit tick counters.
- LFSR_SEED, 16'hACE1: nonzero reset value of the internal LFSR.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- ch_idle  in  1  channel idle, 1 = idle
- tx_req  in  1  level; frame pending; deassert aborts
- tx_done  in  1  one-cycle pulse; transmission finished
- difs_us  in  8  defer time in µs
- slot_us  in  5  slot time in µs
- cw_exp  in  4  contention window exponent; CW = 2^cw_exp-1, clamped to exponent 10
- tx_grant  out  1  medium won; held until tx_done
- backoff_busy  out  1  state is WAIT_DIFS or BACKOFF
- backoff_left  out  10  remaining backoff slots

Behaviour:
- Reset (rstn=0 at posedge):
  - state IDLE; tx_grant=0, backoff_busy=0, backoff_left=0.
  - All counters 0; LFSR=LFSR_SEED.
  - Reset mid-operation drops tx_grant on the next edge.
- Tick targets are registered every cycle:
  - difs_ticks = difs_us*CLK_PER_US
  - slot_ticks = slot_us*CLK_PER_US
  - Both are 16 bits, truncated on overflow.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle out of reset; never zero.
- IDLE:
  - tx_grant=0.
  - On tx_req=1: backoff_left <= LFSR & ((1<<min(cw_exp,10))-1); idle_cnt <= 0; go to WAIT_DIFS.
- WAIT_DIFS:
  - ch_idle=0: idle_cnt <= 0.
  - Otherwise idle_cnt increments.
  - When ch_idle=1 and idle_cnt+1 >= difs_ticks: go to GRANT if backoff_left==0, else BACKOFF with slot_cnt <= 0.
  - difs_ticks=0: leaves after exactly one idle cycle.
- BACKOFF:
  - ch_idle=1: slot_cnt increments.
  - When slot_cnt+1 >= slot_ticks: slot_cnt <= 0 and backoff_left decrements; if the new value is 0, go to GRANT.
  - ch_idle=0: backoff_left frozen, slot_cnt discarded, idle_cnt <= 0, back to WAIT_DIFS.
  - A busy cycle coinciding with slot completion wins: the slot is not counted.
  - slot_ticks=0 is treated as 1.
- GRANT:
  - tx_grant=1 (registered; asserted the cycle after entry); ch_idle ignored.
  - tx_done=1: go to IDLE, tx_grant=0 next cycle.
  - tx_req deassert does not abort GRANT.
- Abort:
  - tx_req=0 in WAIT_DIFS or BACKOFF → IDLE, backoff_left <= 0.
- Priority and timing:
  - Priority within a cycle: rstn > abort/tx_done > ch_idle evaluation.
  - tx_done outside GRANT is ignored.
  - cw_exp and difs_us are sampled continuously; a change mid-defer affects only the remaining comparison; backoff_left is drawn only at IDLE exit.
- Output coding: backoff_busy is combinational from the state register; other outputs are registered.

Test Plan:
- Basic grant: CLK_PER_US=10, difs_us=3, slot_us=1, cw_exp=0, ch_idle=1, tx_req rises at t0 → tx_grant high 32 cycles after t0 (1 IDLE + 30 DIFS + 1 register); drops 1 cycle after tx_done.
- Backoff count: cw_exp=3, force LFSR draw 5 (seed chosen) → grant after 30 DIFS + 50 slot cycles; backoff_left steps 5,4,3,2,1,0 every 10 cycles.
- Freeze: ch_idle=0 for 7 cycles when backoff_left=3 mid-slot → backoff_left holds 3; after idle returns, DIFS reruns (30 cycles) before counting resumes; total slots consumed still 5.
- Collision edge: ch_idle drops exactly on a slot-completion cycle → backoff_left not decremented.
- Abort: tx_req falls during BACKOFF → IDLE next cycle, backoff_left=0, no grant.
- Abort ignored: tx_req falls during GRANT → tx_grant stays 1 until tx_done.
- Reset mid-BACKOFF → all outputs 0 next edge.
- LFSR sweep: 1000 draws with cw_exp=4 → all values in 0..15, never LFSR=0.
